// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the dmem_arbiter slice (FSM states, default widths,
// requester indices). Optional macro DMEM_ARB_ROUND_ROBIN_EN is consumed by dmem_arb_pick.
package dmem_arb_pkg;

    localparam int AW = 16;
    localparam int DW = 32;

    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select for the two-requester memory arbiter.
// Macro DMEM_ARB_ROUND_ROBIN_EN: defined = alternate on ties, undefined = m0 fixed priority.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic m0_req,
    input  logic m1_req,
    input  logic last_served,
    output logic any_req,
    output logic winner
);

    // NOTE: every output gets a default before the branches so no latch is inferred.
    always_comb begin
        any_req = m0_req | m1_req;
        winner  = REQ_M0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        if (m0_req && m1_req) begin
            winner = ~last_served;
        end else if (m1_req) begin
            winner = REQ_M1;
        end
`else
        if (!m0_req && m1_req) begin
            winner = REQ_M1;
        end
`endif
    end

`ifndef DMEM_ARB_ROUND_ROBIN_EN
    // Fixed priority ignores the history input; synthesis trims the upstream flop.
    logic unused_last_served;
    assign unused_last_served = last_served;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer in front of a single-port data_memory.
// Tie policy selected by DMEM_ARB_ROUND_ROBIN_EN (see dmem_arb_pick).
module dmem_arbiter #(
    parameter int AW = dmem_arb_pkg::AW,
    parameter int DW = dmem_arb_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,

    output logic          mem_wEn,
    output logic [AW-1:0] address,
    output logic [DW-1:0] write_data,
    input  logic [DW-1:0] read_data
);

    import dmem_arb_pkg::*;

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          owner_q, owner_d;
    logic          last_served_q, last_served_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [DW-1:0] m0_rdata_hold_q, m0_rdata_hold_d;
    logic [DW-1:0] m1_rdata_hold_q, m1_rdata_hold_d;

    logic any_req;
    logic winner;
    logic arb_en;
    logic grant;
    logic in_access;
    logic in_resp;

    dmem_arb_pick u_pick (
        .m0_req      (m0_req),
        .m1_req      (m1_req),
        .last_served (last_served_q),
        .any_req     (any_req),
        .winner      (winner)
    );

    // Grants and responses are gated by rst so an aborted cycle has no visible side effects.
    assign arb_en    = (state_q == IDLE) || (state_q == RESP);
    assign grant     = arb_en && any_req && !rst;
    assign in_access = (state_q == ACCESS) && !rst;
    assign in_resp   = (state_q == RESP) && !rst;

    assign m0_gnt    = grant && (winner == REQ_M0);
    assign m1_gnt    = grant && (winner == REQ_M1);

    assign mem_wEn    = in_access && we_q;
    assign address    = in_access ? addr_q  : '0;
    assign write_data = in_access ? wdata_q : '0;

    assign m0_rvalid = in_resp && (owner_q == REQ_M0);
    assign m1_rvalid = in_resp && (owner_q == REQ_M1);

    // Each requester sees the fresh response during its rvalid and its last value otherwise.
    assign m0_rdata = m0_rvalid ? rdata_q : m0_rdata_hold_q;
    assign m1_rdata = m1_rvalid ? rdata_q : m1_rdata_hold_q;

    always_comb begin
        state_d         = state_q;
        we_d            = we_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        owner_d         = owner_q;
        last_served_d   = last_served_q;
        rdata_d         = rdata_q;
        m0_rdata_hold_d = m0_rdata_hold_q;
        m1_rdata_hold_d = m1_rdata_hold_q;

        unique case (state_q)
            IDLE, RESP: begin
                if (grant) begin
                    state_d       = ACCESS;
                    we_d          = (winner == REQ_M1) ? m1_we    : m0_we;
                    addr_d        = (winner == REQ_M1) ? m1_addr  : m0_addr;
                    wdata_d       = (winner == REQ_M1) ? m1_wdata : m0_wdata;
                    owner_d       = winner;
                    last_served_d = winner;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (!we_q) begin
                    rdata_d = read_data;
                end
            end
            default: state_d = IDLE;
        endcase

        if (m0_rvalid) begin
            m0_rdata_hold_d = rdata_q;
        end
        if (m1_rvalid) begin
            m1_rdata_hold_d = rdata_q;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            we_q            <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            owner_q         <= REQ_M0;
            last_served_q   <= REQ_M1;
            rdata_q         <= '0;
            m0_rdata_hold_q <= '0;
            m1_rdata_hold_q <= '0;
        end else begin
            state_q         <= state_d;
            we_q            <= we_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            owner_q         <= owner_d;
            last_served_q   <= last_served_d;
            rdata_q         <= rdata_d;
            m0_rdata_hold_q <= m0_rdata_hold_d;
            m1_rdata_hold_q <= m1_rdata_hold_d;
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port `data_memory`.
- Requester 0 is the core load/store unit. Requester 1 is a DMA/debug loader port.
- Serialises accesses, drives the memory's `mem_wEn`/`address`/`write_data` and registers `read_data` back to the winning requester.
- Every access, read or write, is acknowledged with a one-cycle `rvalid` pulse.

Parameters:
- AW, 16, address width; matches the `data_memory` address port.
- DW, 32, data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- m0_req  in  1  requester 0 access request; held until m0_gnt.
- m0_we  in  1  requester 0: 1 = write, 0 = read.
- m0_addr  in  AW  requester 0 address.
- m0_wdata  in  DW  requester 0 write data.
- m0_gnt  out  1  one-cycle pulse; request sampled this cycle.
- m0_rvalid  out  1  one-cycle completion pulse.
- m0_rdata  out  DW  read data; valid while m0_rvalid.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0_*, for requester 1.
- mem_wEn  out  1  memory write enable.
- address  out  AW  memory address.
- write_data  out  DW  memory write data.
- read_data  in  DW  memory read data.

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset:
  - state = IDLE; all gnt/rvalid = 0; rdata registers = 0; owner = 0.
  - Round-robin pointer last_served = 1, so m0 wins the first tie.
  - mem_wEn = 0, address = 0, write_data = 0.
- Arbitration occurs in IDLE or RESP when any req = 1, at cycle T:
  - Winner's gnt = 1 combinationally in cycle T.
  - we/addr/wdata/owner latched at edge T; next state ACCESS.
  - With no req, RESP goes to IDLE and IDLE stays IDLE.
- ACCESS (T+1):
  - address = addr_q, write_data = wdata_q, mem_wEn = we_q & ~rst.
  - Memory write commits at edge T+1.
  - read_data is captured into rdata_q at edge T+1 for reads only; on writes rdata_q holds its value.
  - Next state RESP unconditionally; no gnt issued in ACCESS.
- RESP (T+2):
  - owner's rvalid = 1; owner's rdata = rdata_q.
  - Arbitration for the next access may occur in this same cycle.
- Throughput and latency:
  - Back-to-back throughput: one access per 2 cycles.
  - Read latency: gnt to rvalid = 2 cycles.
- Outside ACCESS:
  - mem_wEn = 0.
  - address and write_data = 0, so no spurious writes and a deterministic bus.
- Requester rules:
  - May drop req the cycle after gnt.
  - Req must not change we/addr/wdata while waiting.
  - A request seen in ACCESS waits; it is never lost.
- Tie rule: both req in the same arbitration cycle → grant the requester not equal to last_served. last_served updates at each grant.
- m*_rdata holds its last value when rvalid = 0.
- Reset mid-operation:
  - rst in ACCESS suppresses mem_wEn that cycle, so the write is not performed.
  - FSM returns to IDLE; no rvalid is produced for the aborted access.
  - rst in RESP suppresses rvalid.
- Width rule: addresses and data pass through unmodified; no byte enables, no alignment checking.

Optional Feature:
- Macro DMEM_ARB_ROUND_ROBIN_EN.
- Defined: tie rule as above (alternating grants under continuous contention).
- Undefined: fixed priority, m0 always wins a tie; last_served register absent. m1 can starve, which is accepted for the debug/DMA use case.

Decomposition:
- Package dmem_arb_pkg holds:
  - state enum (IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2);
  - localparam defaults AW = 16, DW = 32;
  - requester index constants REQ_M0 = 1'b0, REQ_M1 = 1'b1.
- One sub-module, dmem_arb_pick: combinational winner select from {m1_req, m0_req, last_served}. The macro is evaluated only inside it.

Test Plan:
- m0 write addr 16'h006f, data 32'h11100011: m0_gnt at T; mem_wEn = 1 with address = 006f only in T+1; m0_rvalid at T+2.
- Then m0 read 006f: m0_rvalid 2 cycles after gnt with m0_rdata = 32'h11100011; mem_wEn stays 0.
- m0 and m1 both hold continuous reads (m0 @0010, m1 @0020) from reset:
  - macro on: grants alternate m0, m1, m0, m1, with a 2-cycle gnt spacing;
  - macro off: m0 is granted every time.
- m1 writes 32'hdeadbeef @0004, followed in its RESP cycle by an m0 read @0004: m0_gnt coincides with m1_rvalid; m0_rdata = deadbeef.
- m0 write 32'hcafef00d @0008 with rst asserted during ACCESS:
  - mem_wEn = 0 that cycle; no rvalid; FSM in IDLE.
  - A subsequent m0 read @0008 returns the reset contents (0), not cafef00d.
- Idle check: no req for 10 cycles after reset → all gnt/rvalid/mem_wEn = 0, address = 0.
